// File: rtl/fir_axilite_cfg.sv
// AXI-Lite configuration responder for the FIR block.
// Owns the ap_ctrl / data_length registers, fronts the single-port tap RAM
// (1-cycle read latency) and runs the ap_start / ap_done / ap_idle handshake
// with the FIR datapath engine.
module fir_axilite_cfg #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic                   tap_en,
    output logic [3:0]             tap_we,
    output logic [pADDR_WIDTH-1:0] tap_addr,
    output logic [pDATA_WIDTH-1:0] tap_di,
    input  logic [pDATA_WIDTH-1:0] tap_do,
    output logic                   ap_start_o,
    input  logic                   core_done,
    output logic [pDATA_WIDTH-1:0] data_length
);

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL    = pADDR_WIDTH'(32'h00);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN     = pADDR_WIDTH'(32'h10);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAP     = pADDR_WIDTH'(32'h20);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAP_END = pADDR_WIDTH'(32'h20 + Tape_Num);

    typedef enum logic [1:0] {C_IDLE, C_START, C_RUN} cstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

    cstate_t cstate, cnext;
    rstate_t rstate, rnext;

    logic                   wr_gap;
    logic                   wr_acc;
    logic                   ar_acc;
    logic                   wr_tap;
    logic                   rd_tap;
    logic                   start_wr;
    logic                   rd_ctrl_done;
    logic                   ap_idle;
    logic                   ap_done;
    logic [pADDR_WIDTH-1:0] raddr;
    logic                   r_tap_ok;
    logic [pDATA_WIDTH-1:0] rd_val;

    // Byte addresses 0x20 .. 0x20+Tape_Num-1 each map to one tap word.
    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= ADDR_TAP) && (a < ADDR_TAP_END);
    endfunction

    function automatic logic [pADDR_WIDTH-1:0] tap_word(input logic [pADDR_WIDTH-1:0] a);
        return (a - ADDR_TAP) << 2;
    endfunction

    // Handshake decode. Writes are accepted combinationally when both
    // address and data are present; the cycle after an accept is blocked so
    // ready is a single-cycle pulse. A write accept wins the tap RAM port.
    always_comb begin
        wr_acc       = ~axis_rst & awvalid & wvalid & ~wr_gap;
        ar_acc       = ~axis_rst & (rstate == R_IDLE) & arvalid & ~wr_acc;
        wr_tap       = wr_acc & is_tap(awaddr) & ap_idle;
        rd_tap       = ar_acc & is_tap(araddr) & ap_idle;
        start_wr     = wr_acc & (awaddr == ADDR_CTRL) & wdata[0] & ap_idle;
        rd_ctrl_done = (rstate == R_DATA) & rready & (raddr == ADDR_CTRL);
        awready      = wr_acc;
        wready       = wr_acc;
        arready      = ar_acc;
    end

    // Tap RAM port: write data/address in the write handshake cycle, read
    // address in the read-accept cycle so tap_do is ready during R_WAIT.
    always_comb begin
        tap_en   = wr_tap | rd_tap;
        tap_we   = wr_tap ? 4'hF : 4'h0;
        tap_di   = wdata;
        tap_addr = '0;
        if (wr_tap)
            tap_addr = tap_word(awaddr);
        else if (rd_tap)
            tap_addr = tap_word(araddr);
    end

    // Write-accept spacing flag.
    always_ff @(posedge axis_clk) begin
        if (axis_rst)
            wr_gap <= 1'b0;
        else
            wr_gap <= wr_acc;
    end

    // data_length register, frozen while the engine is busy.
    always_ff @(posedge axis_clk) begin
        if (axis_rst)
            data_length <= '0;
        else if (wr_acc && (awaddr == ADDR_LEN) && ap_idle)
            data_length <= wdata;
    end

    // Control FSM state register.
    always_ff @(posedge axis_clk) begin
        if (axis_rst)
            cstate <= C_IDLE;
        else
            cstate <= cnext;
    end

    // Control FSM next state: START lasts one cycle and produces the pulse.
    always_comb begin
        cnext = cstate;
        unique case (cstate)
            C_IDLE:  if (start_wr) cnext = C_START;
            C_START: cnext = C_RUN;
            C_RUN:   if (core_done) cnext = C_IDLE;
            default: cnext = C_IDLE;
        endcase
    end

    // Control FSM outputs.
    always_comb begin
        ap_idle    = (cstate == C_IDLE);
        ap_start_o = (cstate == C_START);
    end

    // Sticky done flag; a completion in the same cycle as a clearing read
    // of ap_ctrl wins so the event is never lost.
    always_ff @(posedge axis_clk) begin
        if (axis_rst)
            ap_done <= 1'b0;
        else if ((cstate == C_RUN) && core_done)
            ap_done <= 1'b1;
        else if (start_wr || rd_ctrl_done)
            ap_done <= 1'b0;
    end

    // Read FSM state register.
    always_ff @(posedge axis_clk) begin
        if (axis_rst)
            rstate <= R_IDLE;
        else
            rstate <= rnext;
    end

    // Read FSM next state: accept, wait one cycle for tap_do, present data.
    always_comb begin
        rnext = rstate;
        unique case (rstate)
            R_IDLE:  if (ar_acc) rnext = R_WAIT;
            R_WAIT:  rnext = R_DATA;
            R_DATA:  if (rready) rnext = R_IDLE;
            default: rnext = R_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        rvalid = (rstate == R_DATA);
    end

    // Read data source selection for the captured address.
    always_comb begin
        rd_val = '0;
        if (raddr == ADDR_CTRL)
            rd_val[2:0] = {ap_idle, ap_done, ap_start_o};
        else if (raddr == ADDR_LEN)
            rd_val = data_length;
        else if (is_tap(raddr))
            rd_val = r_tap_ok ? tap_do : '1;
    end

    // Read address capture at accept and data capture at the end of R_WAIT;
    // rdata then holds steady through any rready back-pressure.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            raddr    <= '0;
            r_tap_ok <= 1'b0;
            rdata    <= '0;
        end else begin
            if (ar_acc) begin
                raddr    <= araddr;
                r_tap_ok <= is_tap(araddr) & ap_idle;
            end
            if (rstate == R_WAIT)
                rdata <= rd_val;
        end
    end

endmodule
